// File: rtl/digi_ota_pkg.sv
// Shared types and constants for the digital-OTA ones-density decimator.
package digi_ota_pkg;

   localparam int CNT_W = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACCUM = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   localparam logic [CNT_W-1:0] WIN_LEN_32  = 9'd32;
   localparam logic [CNT_W-1:0] WIN_LEN_64  = 9'd64;
   localparam logic [CNT_W-1:0] WIN_LEN_128 = 9'd128;
   localparam logic [CNT_W-1:0] WIN_LEN_256 = 9'd256;

   function automatic logic [CNT_W-1:0] win_len(input logic [1:0] sel);
      case (sel)
         2'd0:    return WIN_LEN_32;
         2'd1:    return WIN_LEN_64;
         2'd2:    return WIN_LEN_128;
         default: return WIN_LEN_256;
      endcase
   endfunction

   // A full window maps to 0x80 for the 32..128 sample windows; the 256-sample
   // window is left unscaled, so an all-ones window there is the only case
   // that exceeds the result range.
   function automatic logic [1:0] scale_shift(input logic [1:0] sel);
      case (sel)
         2'd0:    return 2'd2;
         2'd1:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/digi_ota_sync_maj.sv
// Comparator-input synchronizer followed by a 3-sample majority filter.
// Legal SYNC_STAGES range is 2..3; cmp_f lags cmp_in by SYNC_STAGES+2 cycles.
module digi_ota_sync_maj #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic cmp_in,
   output logic cmp_f
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]             hist_q;

   // Synchronizer chain plus three-deep history of the synchronized bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
         hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
      end
   end

   assign cmp_f = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/digi_ota_decim.sv
// Ones-density decimator: counts filtered comparator ones over a selectable
// window and reports a scaled, saturating result with a one-cycle strobe.
//
// state    | meaning
// ST_IDLE  | waiting for en; counters parked
// ST_ACCUM | window accumulating, one sample per cycle
// ST_DONE  | result just loaded, valid high for this cycle
module digi_ota_decim
   import digi_ota_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int OUT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmp_in,
   input  logic             en,
   input  logic [1:0]       win_sel,
   output logic [OUT_W-1:0] result,
   output logic             valid,
   output logic             busy,
   output logic             ovf
);

   localparam logic [31:0] SAT_VAL = 32'((64'd1 << OUT_W) - 64'd1);

   state_e           state_q, state_d;
   logic [1:0]       win_q, win_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] ones_q, ones_d, ones_inc;
   logic [OUT_W-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             cmp_f;
   logic [31:0]      scaled;
   logic             sat;

   digi_ota_sync_maj #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_maj (
      .clk   (clk),
      .rst   (rst),
      .cmp_in(cmp_in),
      .cmp_f (cmp_f)
   );

   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign ones_inc = ones_q + CNT_W'(cmp_f);
   // Scaling uses the count including the current sample so the result is
   // loaded on the same edge that enters DONE, aligned with valid.
   assign scaled   = 32'(ones_inc) << scale_shift(win_q);
   assign sat      = (scaled > SAT_VAL);

   // Next-state, counter and result update logic.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      cnt_d    = cnt_q;
      ones_d   = ones_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               win_d   = win_sel;
               cnt_d   = '0;
               ones_d  = '0;
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (!en) begin
               // Abort wins even on the final sample: partial window dropped.
               cnt_d   = '0;
               ones_d  = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d  = cnt_inc;
               ones_d = ones_inc;
               if (cnt_inc == win_len(win_q)) begin
                  state_d  = ST_DONE;
                  result_d = sat ? SAT_VAL[OUT_W-1:0] : scaled[OUT_W-1:0];
                  if (sat) begin
                     ovf_d = 1'b1;
                  end
               end
            end
         end
         ST_DONE: begin
            cnt_d  = '0;
            ones_d = '0;
            if (en) begin
               win_d   = win_sel;
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         win_q    <= '0;
         cnt_q    <= '0;
         ones_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         cnt_q    <= cnt_d;
         ones_q   <= ones_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result = result_q;
   assign valid  = (state_q == ST_DONE);
   assign busy   = (state_q == ST_ACCUM);
   assign ovf    = ovf_q;

endmodule
